// File: rtl/acq_search_ctrl.sv
// Acquisition search sequencer for one tracking channel.
// Steps a Doppler x code-phase grid and reports the strongest cell.
module acq_search_ctrl #(
    parameter int CODE_PERIOD_HC = 2046,
    parameter int SETTLE_DUMPS   = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [9:0]         prn_key_in,
    input  logic [28:0]        carr_fc_start,
    input  logic signed [15:0] carr_fc_step,
    input  logic [5:0]         doppler_bins,
    input  logic [10:0]        code_bins,
    input  logic [10:0]        code_step_hc,
    input  logic [3:0]         dwell,
    input  logic [35:0]        threshold,
    input  logic               dump,
    input  logic signed [15:0] i_prompt,
    input  logic signed [15:0] q_prompt,
    output logic [9:0]         prn_key,
    output logic               prn_key_enable,
    output logic [28:0]        carr_nco_fc,
    output logic [10:0]        code_slew,
    output logic               slew_enable,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [5:0]         best_dop_idx,
    output logic [10:0]        best_code_pos,
    output logic [35:0]        best_pow,
    output logic               cell_valid,
    output logic [35:0]        cell_pow
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_DWELL, S_EVAL, S_STEP, S_DONE
    } state_t;

    localparam logic [11:0] PERIOD = 12'(CODE_PERIOD_HC);
    localparam logic [15:0] NSETTLE = 16'(SETTLE_DUMPS);

    state_t state_q, state_d;
    logic [9:0]  key_q, key_d;
    logic [15:0] fstep_q, fstep_d;
    logic [5:0]  dbins_q, dbins_d;
    logic [10:0] cbins_q, cbins_d;
    logic [10:0] cstep_q, cstep_d;
    logic [3:0]  dwell_q, dwell_d;
    logic [35:0] thr_q, thr_d;
    logic [5:0]  dop_idx_q, dop_idx_d;
    logic [10:0] code_idx_q, code_idx_d;
    logic [10:0] code_pos_q, code_pos_d;
    logic [15:0] cnt_q, cnt_d;
    logic [35:0] acc_q, acc_d;
    logic [35:0] best_pow_q, best_pow_d;
    logic [5:0]  best_dop_q, best_dop_d;
    logic [10:0] best_code_q, best_code_d;
    logic        found_q, found_d;
    logic [35:0] cell_pow_q, cell_pow_d;
    logic [28:0] carr_q, carr_d;

    logic signed [31:0] i_ext, q_ext, i_sq, q_sq;
    logic [31:0] pwr;
    logic [11:0] pos_sum;
    logic [35:0] best_new;
    logic        last_code, last_dop;

    // Prompt power of the current dump and the wrapped next code position
    always_comb begin
        i_ext = 32'(i_prompt);
        q_ext = 32'(q_prompt);
        i_sq  = i_ext * i_ext;
        q_sq  = q_ext * q_ext;
        pwr   = i_sq + q_sq;
        pos_sum = {1'b0, code_pos_q} + {1'b0, cstep_q};
        if (pos_sum >= PERIOD) pos_sum = pos_sum - PERIOD;
        if (pos_sum >= PERIOD) pos_sum = pos_sum - PERIOD;
        last_code = (code_idx_q == cbins_q - 11'd1);
        last_dop  = (dop_idx_q == dbins_q - 6'd1);
        best_new  = (acc_q > best_pow_q) ? acc_q : best_pow_q;
    end

    // Search sequencer: next state, datapath updates and channel strobes
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        fstep_d     = fstep_q;
        dbins_d     = dbins_q;
        cbins_d     = cbins_q;
        cstep_d     = cstep_q;
        dwell_d     = dwell_q;
        thr_d       = thr_q;
        dop_idx_d   = dop_idx_q;
        code_idx_d  = code_idx_q;
        code_pos_d  = code_pos_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        best_pow_d  = best_pow_q;
        best_dop_d  = best_dop_q;
        best_code_d = best_code_q;
        found_d     = found_q;
        cell_pow_d  = cell_pow_q;
        carr_d      = carr_q;
        prn_key_enable = 1'b0;
        slew_enable    = 1'b0;
        done           = 1'b0;
        cell_valid     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    key_d       = prn_key_in;
                    fstep_d     = carr_fc_step;
                    dbins_d     = (doppler_bins == 6'd0) ? 6'd1 : doppler_bins;
                    cbins_d     = (code_bins == 11'd0) ? 11'd1 : code_bins;
                    cstep_d     = code_step_hc;
                    dwell_d     = (dwell == 4'd0) ? 4'd1 : dwell;
                    thr_d       = threshold;
                    carr_d      = carr_fc_start;
                    dop_idx_d   = '0;
                    code_idx_d  = '0;
                    code_pos_d  = '0;
                    cnt_d       = '0;
                    acc_d       = '0;
                    best_pow_d  = '0;
                    best_dop_d  = '0;
                    best_code_d = '0;
                    found_d     = 1'b0;
                end
            end
            S_LOAD: begin
                prn_key_enable = 1'b1;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (NSETTLE == 16'd0) begin
                    state_d = S_DWELL;
                end else if (dump) begin
                    if (cnt_q + 16'd1 == NSETTLE) begin
                        cnt_d   = '0;
                        state_d = S_DWELL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DWELL: begin
                if (dump) begin
                    acc_d = acc_q + 36'(pwr);
                    if (cnt_q + 16'd1 == {12'd0, dwell_q}) begin
                        cnt_d      = '0;
                        cell_pow_d = acc_q + 36'(pwr);
                        state_d    = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_EVAL: begin
                cell_valid = 1'b1;
                acc_d      = '0;
                if (acc_q > best_pow_q) begin
                    best_pow_d  = acc_q;
                    best_dop_d  = dop_idx_q;
                    best_code_d = code_pos_q;
                end
                if (last_code && last_dop) begin
                    found_d = (best_new >= thr_q);
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (!last_code) begin
                    slew_enable = (cstep_q != 11'd0);
                    code_pos_d  = pos_sum[10:0];
                    code_idx_d  = code_idx_q + 11'd1;
                end else begin
                    code_idx_d = '0;
                    carr_d     = carr_q + {{13{fstep_q[15]}}, fstep_q};
                    dop_idx_d  = dop_idx_q + 6'd1;
                end
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous abort on reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            fstep_q     <= '0;
            dbins_q     <= 6'd1;
            cbins_q     <= 11'd1;
            cstep_q     <= '0;
            dwell_q     <= 4'd1;
            thr_q       <= '0;
            dop_idx_q   <= '0;
            code_idx_q  <= '0;
            code_pos_q  <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            best_pow_q  <= '0;
            best_dop_q  <= '0;
            best_code_q <= '0;
            found_q     <= 1'b0;
            cell_pow_q  <= '0;
            carr_q      <= 29'h1000_0000;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            fstep_q     <= fstep_d;
            dbins_q     <= dbins_d;
            cbins_q     <= cbins_d;
            cstep_q     <= cstep_d;
            dwell_q     <= dwell_d;
            thr_q       <= thr_d;
            dop_idx_q   <= dop_idx_d;
            code_idx_q  <= code_idx_d;
            code_pos_q  <= code_pos_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            best_pow_q  <= best_pow_d;
            best_dop_q  <= best_dop_d;
            best_code_q <= best_code_d;
            found_q     <= found_d;
            cell_pow_q  <= cell_pow_d;
            carr_q      <= carr_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign prn_key       = key_q;
    assign carr_nco_fc   = carr_q;
    assign code_slew     = cstep_q;
    assign found         = found_q;
    assign best_dop_idx  = best_dop_q;
    assign best_code_pos = best_code_q;
    assign best_pow      = best_pow_q;
    assign cell_pow      = cell_pow_q;

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Scoreboard bench for acq_search_ctrl with a reactive channel model.
// Expected cell powers are queued at start and popped on cell_valid.
module tb_acq_search_ctrl;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic [9:0]         prn_key_in;
    logic [28:0]        carr_fc_start;
    logic signed [15:0] carr_fc_step;
    logic [5:0]         doppler_bins;
    logic [10:0]        code_bins;
    logic [10:0]        code_step_hc;
    logic [3:0]         dwell;
    logic [35:0]        threshold;
    logic               dump;
    logic signed [15:0] i_prompt;
    logic signed [15:0] q_prompt;
    logic [9:0]         prn_key;
    logic               prn_key_enable;
    logic [28:0]        carr_nco_fc;
    logic [10:0]        code_slew;
    logic               slew_enable;
    logic               busy;
    logic               done;
    logic               found;
    logic [5:0]         best_dop_idx;
    logic [10:0]        best_code_pos;
    logic [35:0]        best_pow;
    logic               cell_valid;
    logic [35:0]        cell_pow;

    acq_search_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start),
        .prn_key_in(prn_key_in), .carr_fc_start(carr_fc_start),
        .carr_fc_step(carr_fc_step), .doppler_bins(doppler_bins),
        .code_bins(code_bins), .code_step_hc(code_step_hc),
        .dwell(dwell), .threshold(threshold), .dump(dump),
        .i_prompt(i_prompt), .q_prompt(q_prompt),
        .prn_key(prn_key), .prn_key_enable(prn_key_enable),
        .carr_nco_fc(carr_nco_fc), .code_slew(code_slew),
        .slew_enable(slew_enable), .busy(busy), .done(done),
        .found(found), .best_dop_idx(best_dop_idx),
        .best_code_pos(best_code_pos), .best_pow(best_pow),
        .cell_valid(cell_valid), .cell_pow(cell_pow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [35:0] exp_q[$];
    int cells_seen = 0;
    int slews = 0;
    int nco_steps = 0;
    int keyens = 0;
    int dones = 0;
    int cur_step = 0;
    int run_id = 0;
    logic [28:0] carr_prev = 29'h1000_0000;
    logic busy_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // advance to the next falling edge and observe DUT strobes
    task automatic tick();
        @(negedge clk);
        if (cell_valid) begin
            cells_seen++;
            if (exp_q.size() == 0) chk("sb_empty", 64'(exp_q.size()), 1);
            else chk("cell_pow", cell_pow, exp_q.pop_front());
        end
        if (slew_enable) begin
            slews++;
            chk("code_slew", code_slew, 64'(cur_step));
        end
        if (prn_key_enable) keyens++;
        if (done) dones++;
        if (busy && busy_prev && carr_nco_fc != carr_prev) nco_steps++;
        carr_prev = carr_nco_fc;
        busy_prev = busy;
    endtask

    task automatic run(input int db, input int cb, input int step,
                       input int fstep, input int dw, input longint thr,
                       input int pd, input int pc, input bit seq,
                       input bit restart);
        int edb, ecb, edw, p, bd, bc, k, cyc, nd;
        int k0, s0, n0, d0, c0;
        logic [35:0] best;
        logic [28:0] ecarr;
        logic [9:0] key;
        bit tout;
        key = 10'(run_id * 37 + 5);
        run_id++;
        edb = (db == 0) ? 1 : db;
        ecb = (cb == 0) ? 1 : cb;
        edw = (dw == 0) ? 1 : dw;
        doppler_bins  = 6'(db);
        code_bins     = 11'(cb);
        code_step_hc  = 11'(step);
        carr_fc_step  = 16'(fstep);
        dwell         = 4'(dw);
        threshold     = 36'(thr);
        prn_key_in    = key;
        carr_fc_start = 29'h1000_0000;
        cur_step      = step;
        best = '0;
        bd = 0;
        bc = 0;
        for (int i = 0; i < edb * ecb; i++) begin
            int d;
            int c;
            d = i / ecb;
            c = i % ecb;
            if (seq) p = edw * 10000;
            else if (d == pd && c == pc) p = edw * 250000;
            else p = edw * 200;
            exp_q.push_back(36'(p));
            if (36'(p) > best) begin
                best = 36'(p);
                bd = d;
                bc = ((d * (ecb - 1) + c) * step) % 2046;
            end
        end
        ecarr = 29'(268435456 + (edb - 1) * fstep);
        k0 = keyens;
        s0 = slews;
        n0 = nco_steps;
        d0 = dones;
        c0 = cells_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("key_en", prn_key_enable, 1);
        chk("busy_up", busy, 1);
        chk("prn_key", prn_key, key);
        prn_key_in = ~key;
        cyc = 0;
        nd = 0;
        tout = 1'b1;
        while (cyc < 20000) begin
            if (done) begin
                tout = 1'b0;
                break;
            end
            start = restart && (cyc == 20);
            if (cyc % 8 == 3) begin
                dump = 1'b1;
                if (seq) begin
                    i_prompt = (nd == 0) ? 16'sd999 : 16'sd100;
                    q_prompt = (nd == 0) ? 16'sd999 : 16'sd0;
                end else begin
                    k = cells_seen - c0;
                    if (k / ecb == pd && k % ecb == pc) begin
                        i_prompt = 16'sd500;
                        q_prompt = 16'sd0;
                    end else begin
                        i_prompt = 16'sd10;
                        q_prompt = 16'sd10;
                    end
                end
                nd++;
            end else begin
                dump = 1'b0;
            end
            tick();
            cyc++;
        end
        dump = 1'b0;
        start = 1'b0;
        chk("timeout", 64'(tout), 0);
        chk("found", found, 64'(best >= 36'(thr)));
        chk("best_pow", best_pow, best);
        chk("best_dop", best_dop_idx, 64'(bd));
        chk("best_code", best_code_pos, 64'(bc));
        chk("key_hold", prn_key, key);
        chk("key_pulses", 64'(keyens - k0), 1);
        chk("slews", 64'(slews - s0), 64'((step == 0) ? 0 : edb * (ecb - 1)));
        chk("nco_steps", 64'(nco_steps - n0), 64'(edb - 1));
        chk("carr_end", carr_nco_fc, ecarr);
        chk("cells", 64'(cells_seen - c0), 64'(edb * ecb));
        chk("sb_left", 64'(exp_q.size()), 0);
        if (tout) exp_q.delete();
        tick();
        chk("busy_down", busy, 0);
        chk("done_pulses", 64'(dones - d0), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_bdop"}, best_dop_idx, 0);
        chk({tag, "_bcode"}, best_code_pos, 0);
        chk({tag, "_bpow"}, best_pow, 0);
        chk({tag, "_cpow"}, cell_pow, 0);
        chk({tag, "_cval"}, cell_valid, 0);
        chk({tag, "_carr"}, carr_nco_fc, 29'h1000_0000);
        chk({tag, "_slew"}, code_slew, 0);
        chk({tag, "_key"}, prn_key, 0);
        chk({tag, "_keyen"}, prn_key_enable, 0);
        chk({tag, "_slewen"}, slew_enable, 0);
    endtask

    initial begin
        int k0, s0, d0;
        rstn = 1'b0;
        start = 1'b0;
        dump = 1'b0;
        i_prompt = '0;
        q_prompt = '0;
        prn_key_in = 10'h3a5;
        carr_fc_start = 29'h0abc_def0;
        carr_fc_step = '0;
        doppler_bins = 6'd1;
        code_bins = 11'd1;
        code_step_hc = '0;
        dwell = 4'd1;
        threshold = '0;

        repeat (10) tick();
        chk_reset_outputs("rst");
        rstn = 1'b1;
        k0 = keyens;
        s0 = slews;
        repeat (100) tick();
        chk_reset_outputs("idle");
        chk("idle_keyen", 64'(keyens - k0), 0);
        chk("idle_slews", 64'(slews - s0), 0);

        run(1, 1, 0, 0, 2, 20000, -1, -1, 1'b1, 1'b0);
        run(1, 1, 0, 0, 2, 20001, -1, -1, 1'b1, 1'b0);
        run(3, 4, 2, -167, 1, 1000, 1, 2, 1'b0, 1'b0);
        run(1, 3, 1023, 0, 1, 0, -1, -1, 1'b0, 1'b0);
        run(1, 3, 1023, 0, 1, 300, 0, 2, 1'b0, 1'b0);
        run(2, 2, 0, 100, 3, 0, -1, -1, 1'b0, 1'b1);
        run(0, 0, 5, 7, 0, 250000, 0, 0, 1'b0, 1'b0);

        doppler_bins = 6'd2;
        code_bins = 11'd2;
        code_step_hc = 11'd3;
        carr_fc_step = 16'sd50;
        carr_fc_start = 29'h0abc_def0;
        dwell = 4'd4;
        threshold = '0;
        prn_key_in = 10'h2c3;
        cur_step = 3;
        d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            dump = (cyc % 8 == 3);
            i_prompt = 16'sd50;
            q_prompt = 16'sd50;
            tick();
        end
        dump = 1'b0;
        chk("abort_busy_pre", busy, 1);
        rstn = 1'b0;
        tick();
        chk_reset_outputs("abort");
        rstn = 1'b1;
        repeat (50) tick();
        chk("abort_done", 64'(dones - d0), 0);
        chk("abort_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
